// File: rtl/ttl_cen_gen_pkg.sv
// Shared types and width helpers for the TTL pseudo-clock generator.
package ttl_cen_gen_pkg;

   // Pause handshake states.
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      STOPPING = 2'd1,
      STOPPED  = 2'd2
   } cen_state_t;

   // Accumulator sum needs one carry bit above the accumulator width.
   localparam int unsigned ACC_CARRY_BITS = 1;

   function automatic int unsigned acc_sum_w(input int unsigned w);
      return w + ACC_CARRY_BITS;
   endfunction

endpackage

// File: rtl/ttl_cen_gen_if.sv
// Pseudo-clock bus between the generator (slave side) and its user (master side).
// Optional macro TTL_CEN_GEN_RESYNC_EN adds the resync request line.
//   pause_req : request to stop the pseudo-clock at low level
//   paused    : generator is stopped
//   cen_lvl / cen_rise / cen_fall : base level and its one-cycle strobes
//   div_lvl / div_rise            : divider levels and per-bit rise strobes
interface ttl_cen_gen_if #(
   parameter int unsigned DIVW = 4
) ();
   logic            pause_req;
   logic            paused;
   logic            cen_lvl;
   logic            cen_rise;
   logic            cen_fall;
   logic [DIVW-1:0] div_lvl;
   logic [DIVW-1:0] div_rise;
`ifdef TTL_CEN_GEN_RESYNC_EN
   logic            resync;
`endif

   modport master (
`ifdef TTL_CEN_GEN_RESYNC_EN
      output resync,
`endif
      output pause_req,
      input  paused, cen_lvl, cen_rise, cen_fall, div_lvl, div_rise
   );

   modport slave (
`ifdef TTL_CEN_GEN_RESYNC_EN
      input  resync,
`endif
      input  pause_req,
      output paused, cen_lvl, cen_rise, cen_fall, div_lvl, div_rise
   );
endinterface

// File: rtl/ttl_cen_gen_edge_strobe.sv
// ttl_edge_strobe: registers an N-bit level and derives one-cycle rise/fall
// strobes that are aligned with the level change (strobe and new level
// appear on the same edge).
//   clk, rst  : clock, synchronous active-high reset
//   lvl_d_i   : next value of the level
//   lvl_o     : registered level
//   rise_o    : per-bit 0->1 strobe
//   fall_o    : per-bit 1->0 strobe
module ttl_edge_strobe #(
   parameter int unsigned N = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] lvl_d_i,
   output logic [N-1:0] lvl_o,
   output logic [N-1:0] rise_o,
   output logic [N-1:0] fall_o
);
   logic [N-1:0] lvl_q;
   logic [N-1:0] rise_q;
   logic [N-1:0] fall_q;

   // Strobes compare the incoming level with the currently held one.
   always_ff @(posedge clk) begin
      if (rst) begin
         lvl_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         lvl_q  <= lvl_d_i;
         rise_q <= lvl_d_i & ~lvl_q;
         fall_q <= ~lvl_d_i & lvl_q;
      end
   end

   assign lvl_o  = lvl_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;
endmodule

// File: rtl/ttl_cen_gen.sv
// ttl_cen_gen: fractional-rate pseudo-clock level generator with a ripple
// style divider chain and a runt-free pause handshake.
// Optional macro TTL_CEN_GEN_RESYNC_EN: a rising edge on bus.resync restarts
// the phase accumulator, levels and divider.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : ttl_cen_gen_if slave (pause handshake, levels, strobes)
module ttl_cen_gen
   import ttl_cen_gen_pkg::*;
#(
   parameter int unsigned W    = 16,
   parameter int unsigned NUM  = 1,
   parameter int unsigned DEN  = 4,
   parameter int unsigned DIVW = 4
) (
   input  logic         clk,
   input  logic         rst,
   ttl_cen_gen_if.slave bus
);
   localparam int unsigned SW = acc_sum_w(W);

   if ((64'(DEN) >= (64'(1) << (W - 1))) || (NUM < 1) || (NUM > DEN)) begin : g_param_err
      $error("ttl_cen_gen: need DEN < 2**(W-1) and 1 <= NUM <= DEN");
   end

   cen_state_t      state_q, state_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [SW-1:0]   sum_c;
   logic            tick_c;
   logic            do_acc_c;
   logic            paused_q, paused_d;
   logic            cen_d;
   logic            cen_lvl;
   logic            resync_edge_c;
   logic [DIVW-1:0] div_d;
   logic [DIVW-1:0] div_lvl;
   logic [DIVW-1:0] div_fall_unused;

`ifdef TTL_CEN_GEN_RESYNC_EN
   logic resync_q;

   // Resets to 1 so a resync already high out of reset is not an edge.
   always_ff @(posedge clk) begin
      if (rst) resync_q <= 1'b1;
      else     resync_q <= bus.resync;
   end

   assign resync_edge_c = bus.resync & ~resync_q;
`else
   assign resync_edge_c = 1'b0;
`endif

   assign sum_c  = SW'(acc_q) + SW'(NUM);
   assign tick_c = (sum_c >= SW'(DEN));

   // Next-state: pause handshake, accumulator step, divider increment.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      paused_d = paused_q;
      cen_d    = cen_lvl;
      div_d    = div_lvl;
      do_acc_c = 1'b0;

      unique case (state_q)
         RUN, STOPPING: begin
            if (bus.pause_req && !cen_lvl) begin
               // Already low: stop immediately, keep the low-phase count.
               state_d  = STOPPED;
               paused_d = 1'b1;
            end else begin
               do_acc_c = 1'b1;
               if (!bus.pause_req) begin
                  state_d = RUN;
               end else if (tick_c) begin
                  // This tick is the fall of the high phase.
                  state_d  = STOPPED;
                  paused_d = 1'b1;
               end else begin
                  state_d = STOPPING;
               end
            end
         end
         STOPPED: begin
            if (!bus.pause_req) begin
               state_d  = RUN;
               paused_d = 1'b0;
            end
         end
         default: state_d = RUN;
      endcase

      if (do_acc_c) begin
         if (tick_c) begin
            acc_d = W'(sum_c - SW'(DEN));
            cen_d = ~cen_lvl;
            if (!cen_lvl) div_d = div_lvl + DIVW'(1);
         end else begin
            acc_d = W'(sum_c);
         end
      end

      if (resync_edge_c) begin
         state_d  = RUN;
         acc_d    = '0;
         paused_d = 1'b0;
         cen_d    = 1'b0;
         div_d    = '0;
      end
   end

   // State, accumulator and pause flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         acc_q    <= '0;
         paused_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         paused_q <= paused_d;
      end
   end

   ttl_edge_strobe #(.N(1)) u_cen_strobe (
      .clk     (clk),
      .rst     (rst),
      .lvl_d_i (cen_d),
      .lvl_o   (cen_lvl),
      .rise_o  (bus.cen_rise),
      .fall_o  (bus.cen_fall)
   );

   ttl_edge_strobe #(.N(DIVW)) u_div_strobe (
      .clk     (clk),
      .rst     (rst),
      .lvl_d_i (div_d),
      .lvl_o   (div_lvl),
      .rise_o  (bus.div_rise),
      .fall_o  (div_fall_unused)
   );

   assign bus.cen_lvl = cen_lvl;
   assign bus.div_lvl = div_lvl;
   assign bus.paused  = paused_q;
endmodule

// File: tb/tb_ttl_cen_gen.sv
// Bench for ttl_cen_gen: a table of checkpoints on a NUM=1/DEN=4 instance,
// plus hand-written sequences for a NUM=3/DEN=8 rate, a NUM=DEN/DIVW=2
// instance, mid-run reset and (with TTL_CEN_GEN_RESYNC_EN) resync.
module tb_ttl_cen_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ttl_cen_gen_if #(.DIVW(4)) if1 ();
   ttl_cen_gen_if #(.DIVW(4)) if2 ();
   ttl_cen_gen_if #(.DIVW(2)) if3 ();

   ttl_cen_gen #(.W(16), .NUM(1), .DEN(4), .DIVW(4)) u1 (.clk(clk), .rst(rst), .bus(if1));
   ttl_cen_gen #(.W(16), .NUM(3), .DEN(8), .DIVW(4)) u2 (.clk(clk), .rst(rst), .bus(if2));
   ttl_cen_gen #(.W(8),  .NUM(4), .DEN(4), .DIVW(2)) u3 (.clk(clk), .rst(rst), .bus(if3));

   typedef struct {
      bit          rst_before;
      int unsigned n;
      bit          pause;
      bit          lvl;
      bit          rise;
      bit          fall;
      bit          paused;
      int unsigned div;
      int unsigned ns;
      int unsigned np;
   } vec_t;

   vec_t        vt[$];
   int unsigned n_tot = 0;
   int unsigned n_bad = 0;
   int unsigned cur_n = 0;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_tot++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cur_n++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      if1.pause_req = 1'b0;
      if2.pause_req = 1'b0;
      if3.pause_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cur_n = 0;
   endtask

   task automatic add(input bit r, input int unsigned n, input bit p, input bit l,
                      input bit ri, input bit fa, input bit pa, input int unsigned dv,
                      input int unsigned ns, input int unsigned np);
      vec_t v;
      v.rst_before = r; v.n = n; v.pause = p; v.lvl = l; v.rise = ri;
      v.fall = fa; v.paused = pa; v.div = dv; v.ns = ns; v.np = np;
      vt.push_back(v);
   endtask

   logic [1:0] exp_div[8];
   logic [1:0] exp_dr[8];

   initial begin
      vec_t        v;
      int unsigned ns, np;
      int unsigned ticks, last_tick, min_sp, max_sp, sp;
      int unsigned win[8];

      if1.pause_req = 1'b0;
      if2.pause_req = 1'b0;
      if3.pause_req = 1'b0;
`ifdef TTL_CEN_GEN_RESYNC_EN
      if1.resync = 1'b0;
      if2.resync = 1'b0;
      if3.resync = 1'b0;
`endif
      exp_div = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_dr  = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00};

      // Free run (r, n, pause, lvl, rise, fall, paused, div, strobes-between, paused-between)
      add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 4, 0, 1, 1, 0, 0, 1, 0, 0);
      add(0, 5, 0, 1, 0, 0, 0, 1, 0, 0);
      add(0, 8, 0, 0, 0, 1, 0, 1, 0, 0);
      add(0, 12, 0, 1, 1, 0, 0, 2, 0, 0);
      add(0, 16, 0, 0, 0, 1, 0, 2, 0, 0);
      add(0, 20, 0, 1, 1, 0, 0, 3, 0, 0);
      add(0, 24, 0, 0, 0, 1, 0, 3, 0, 0);
      add(0, 28, 0, 1, 1, 0, 0, 4, 0, 0);
      add(0, 32, 0, 0, 0, 1, 0, 4, 0, 0);
      add(0, 36, 0, 1, 1, 0, 0, 5, 0, 0);
      add(0, 40, 0, 0, 0, 1, 0, 5, 0, 0);
      // Pause requested during the high phase, released at edge 20
      add(1, 4, 0, 1, 1, 0, 0, 1, 0, 0);
      add(0, 5, 1, 1, 0, 0, 0, 1, 0, 0);
      add(0, 7, 1, 1, 0, 0, 0, 1, 0, 0);
      add(0, 8, 1, 0, 0, 1, 1, 1, 0, 0);
      add(0, 19, 1, 0, 0, 0, 1, 1, 0, 10);
      add(0, 20, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 23, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 24, 0, 1, 1, 0, 0, 2, 0, 0);
      add(0, 28, 0, 0, 0, 1, 0, 2, 0, 0);
      // Short pause pulse inside the high phase: no visible effect
      add(1, 4, 0, 1, 1, 0, 0, 1, 0, 0);
      add(0, 6, 1, 1, 0, 0, 0, 1, 0, 0);
      add(0, 8, 0, 0, 0, 1, 0, 1, 0, 0);
      add(0, 12, 0, 1, 1, 0, 0, 2, 0, 0);
      add(0, 16, 0, 0, 0, 1, 0, 2, 0, 0);
      // Pause while low stops at once and holds the low-phase count
      add(1, 2, 1, 0, 0, 0, 1, 0, 0, 1);
      add(0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 6, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 7, 0, 1, 1, 0, 0, 1, 0, 0);

      // Reset state on every instance
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst u1 outputs", {if1.paused, if1.cen_lvl, if1.cen_rise, if1.cen_fall, if1.div_lvl, if1.div_rise}, 0);
      chk("rst u2 outputs", {if2.paused, if2.cen_lvl, if2.cen_rise, if2.cen_fall, if2.div_lvl, if2.div_rise}, 0);
      chk("rst u3 outputs", {if3.paused, if3.cen_lvl, if3.cen_rise, if3.cen_fall, if3.div_lvl, if3.div_rise}, 0);
      rst = 1'b0;
      cur_n = 0;

      foreach (vt[i]) begin
         v = vt[i];
         ns = 0;
         np = 0;
         if (v.rst_before) do_reset();
         if1.pause_req = v.pause;
         while (cur_n < v.n) begin
            step();
            if (cur_n < v.n) begin
               ns += 32'(if1.cen_rise) + 32'(if1.cen_fall);
               np += 32'(if1.paused);
            end
         end
         chk($sformatf("vec%0d e%0d cen_lvl", i, v.n), 32'(if1.cen_lvl), 32'(v.lvl));
         chk($sformatf("vec%0d e%0d cen_rise", i, v.n), 32'(if1.cen_rise), 32'(v.rise));
         chk($sformatf("vec%0d e%0d cen_fall", i, v.n), 32'(if1.cen_fall), 32'(v.fall));
         chk($sformatf("vec%0d e%0d paused", i, v.n), 32'(if1.paused), 32'(v.paused));
         chk($sformatf("vec%0d e%0d div_lvl", i, v.n), 32'(if1.div_lvl), v.div);
         chk($sformatf("vec%0d strobes before e%0d", i, v.n), ns, v.ns);
         chk($sformatf("vec%0d paused cycles before e%0d", i, v.n), np, v.np);
      end

      // Reset in the middle of a high phase: no fall strobe
      do_reset();
      repeat (6) step();
      chk("mid pre-rst cen_lvl", 32'(if1.cen_lvl), 1);
      rst = 1'b1;
      step();
      chk("mid rst outputs", {if1.paused, if1.cen_lvl, if1.cen_rise, if1.cen_fall, if1.div_lvl, if1.div_rise}, 0);
      rst = 1'b0;
      cur_n = 0;
      repeat (3) step();
      chk("mid rst e3 cen_lvl", 32'(if1.cen_lvl), 0);
      step();
      chk("mid rst e4 cen_rise", 32'(if1.cen_rise), 1);

      // NUM=3, DEN=8: 3 ticks per 8 edges, spacing 2 or 3
      do_reset();
      ticks = 0; last_tick = 0; min_sp = 999; max_sp = 0;
      foreach (win[k]) win[k] = 0;
      for (int e = 1; e <= 64; e++) begin
         step();
         if (if2.cen_rise || if2.cen_fall) begin
            ticks++;
            win[(e - 1) / 8]++;
            if (last_tick != 0) begin
               sp = 32'(e) - last_tick;
               if (sp < min_sp) min_sp = sp;
               if (sp > max_sp) max_sp = sp;
            end
            last_tick = 32'(e);
         end
      end
      chk("frac ticks in 64", ticks, 24);
      chk("frac min spacing", min_sp, 2);
      chk("frac max spacing", max_sp, 3);
      for (int k = 0; k < 8; k++) chk($sformatf("frac window %0d ticks", k), win[k], 3);

      // NUM=DEN with DIVW=2: toggle every edge, 2-bit divider wrap
      do_reset();
      for (int e = 1; e <= 16; e++) begin
         step();
         chk($sformatf("full e%0d cen_rise", e), 32'(if3.cen_rise), 32'(e % 2));
         chk($sformatf("full e%0d cen_fall", e), 32'(if3.cen_fall), 32'(1 - (e % 2)));
         if ((e % 2) == 1) begin
            chk($sformatf("full rise%0d div_lvl", (e + 1) / 2), 32'(if3.div_lvl), 32'(exp_div[(e - 1) / 2]));
            chk($sformatf("full rise%0d div_rise", (e + 1) / 2), 32'(if3.div_rise), 32'(exp_dr[(e - 1) / 2]));
         end else begin
            chk($sformatf("full e%0d div_rise idle", e), 32'(if3.div_rise), 0);
         end
      end

`ifdef TTL_CEN_GEN_RESYNC_EN
      // Resync rising edge during the high phase
      do_reset();
      repeat (6) step();
      if1.resync = 1'b1;
      step();
      chk("resync cen_lvl", 32'(if1.cen_lvl), 0);
      chk("resync cen_fall", 32'(if1.cen_fall), 1);
      chk("resync div_lvl", 32'(if1.div_lvl), 0);
      repeat (3) step();
      chk("resync +3 cen_lvl", 32'(if1.cen_lvl), 0);
      step();
      chk("resync +4 cen_rise", 32'(if1.cen_rise), 1);
      repeat (4) step();
      chk("resync held +8 cen_fall", 32'(if1.cen_fall), 1);
      if1.resync = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
